// File: rtl/calc_pkg.sv
// Shared types and constants for the percent-to-count scaler.
package calc_pkg;

    // Sequencer states: idle, shift-add multiply, serial divide by 100.
    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv
    } state_e;

    localparam int unsigned PCT_DIVISOR = 100;
    localparam int unsigned PCT_ROUND   = 50;
    localparam int unsigned PCT_MAX     = 100;

endpackage

// File: rtl/serial_div100.sv
// Restoring divider by the constant PCT_DIVISOR, one quotient bit per clock.
// A load pulse starts N iterations; valid and quotient are presented
// combinationally during the final iteration so the caller can register them
// on the same edge that retires the divide.
module serial_div100
    import calc_pkg::*;
#(
    parameter int unsigned N = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] dividend,
    output logic [N-1:0] quotient,
    output logic         valid
);

    localparam int unsigned CntW = $clog2(N);
    localparam int unsigned RemW = $clog2(PCT_DIVISOR);

    // Dividend shifts out at the MSB while quotient bits shift in at the LSB.
    logic [N-1:0]    shreg_q, shreg_d;
    logic [RemW-1:0] rem_q, rem_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    logic [RemW:0]   trial;
    logic            qbit;
    logic [RemW-1:0] rem_next;
    logic            last;

    // One restoring step: trial-subtract the divisor from the shifted remainder.
    always_comb begin
        trial    = {rem_q, shreg_q[N-1]};
        qbit     = (trial >= (RemW+1)'(PCT_DIVISOR));
        rem_next = qbit ? RemW'(trial - (RemW+1)'(PCT_DIVISOR)) : trial[RemW-1:0];
        last     = run_q && (cnt_q == CntW'(N - 1));
        valid    = last;
        quotient = {shreg_q[N-2:0], qbit};
    end

    // Next-state for the iteration registers.
    always_comb begin
        shreg_d = shreg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        if (load) begin
            shreg_d = dividend;
            rem_d   = '0;
            cnt_d   = '0;
            run_d   = 1'b1;
        end else if (run_q) begin
            shreg_d = {shreg_q[N-2:0], qbit};
            rem_d   = rem_next;
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    // Iteration state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/calc_scale.sv
// value = round(percent * full_scale / 100), computed serially: PCT_W shift-add
// steps followed by WIDTH+PCT_W restoring divide steps, fixed latency.
// Optional build macro CALC_SCALE_CLAMP_EN limits percent to 100 at capture
// and ties ovf low.
module calc_scale
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PCT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PCT_W-1:0] percent,
    input  logic [WIDTH-1:0] full_scale,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    localparam int unsigned PW    = WIDTH + PCT_W;
    localparam int unsigned StepW = $clog2(PCT_W);

    state_e state_q, state_d;

    logic [PCT_W-1:0] mplier_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [StepW-1:0] step_q;
    logic [WIDTH-1:0] value_q;
    logic             ovf_q;
    logic             done_q;

    logic [PCT_W-1:0] pct_cap;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    div_dividend;
    logic             mult_last;
    logic [PW-1:0]    div_quotient;
    logic             div_valid;
    logic             quot_big;

    // Operand conditioning and the current shift-add partial product.
    always_comb begin
`ifdef CALC_SCALE_CLAMP_EN
        pct_cap = (percent > PCT_W'(PCT_MAX)) ? PCT_W'(PCT_MAX) : percent;
`else
        pct_cap = percent;
`endif
        prod         = acc_q + (mplier_q[0] ? mcand_q : '0);
        div_dividend = prod + PW'(PCT_ROUND);
        mult_last    = (state_q == StMult) && (step_q == StepW'(PCT_W - 1));
        quot_big     = (div_quotient[PW-1:WIDTH] != '0);
    end

    // The final multiply step doubles as the divider load strobe.
    serial_div100 #(
        .N (PW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (mult_last),
        .dividend (div_dividend),
        .quotient (div_quotient),
        .valid    (div_valid)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)     state_d = StMult;
            StMult:  if (mult_last) state_d = StDiv;
            StDiv:   if (div_valid) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    // Datapath: capture, shift-add multiply, and result registration.
    always_ff @(posedge clk) begin
        if (reset) begin
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            value_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mplier_q <= pct_cap;
                        mcand_q  <= {{PCT_W{1'b0}}, full_scale};
                        acc_q    <= '0;
                        step_q   <= '0;
                    end
                end
                StMult: begin
                    acc_q    <= prod;
                    mcand_q  <= {mcand_q[PW-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[PCT_W-1:1]};
                    step_q   <= step_q + 1'b1;
                end
                StDiv: begin
                    if (div_valid) begin
                        value_q <= quot_big ? '1 : div_quotient[WIDTH-1:0];
`ifdef CALC_SCALE_CLAMP_EN
                        ovf_q   <= 1'b0;
`else
                        ovf_q   <= quot_big;
`endif
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy  = (state_q != StIdle);
        done  = done_q;
        value = value_q;
        ovf   = ovf_q;
    end

endmodule

// File: tb/tb_calc_scale.sv
// Randomized and directed bench for calc_scale against an arithmetic model.
// Honours CALC_SCALE_CLAMP_EN the same way the design does.
module tb_calc_scale;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned PCT_W = 8;
    localparam int LATENCY = 2 * PCT_W + WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [PCT_W-1:0] percent;
    logic [WIDTH-1:0] full_scale;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] value;
    logic             ovf;

    int n_cmp = 0;
    int n_err = 0;

    calc_scale #(
        .WIDTH (WIDTH),
        .PCT_W (PCT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .percent    (percent),
        .full_scale (full_scale),
        .busy       (busy),
        .done       (done),
        .value      (value),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: round-half-up of pct*fs/100 with saturation.
    task automatic model(input int p, input int f, output longint v, output longint o);
        longint pe;
        longint q;
        pe = p;
`ifdef CALC_SCALE_CLAMP_EN
        if (pe > 100) pe = 100;
`endif
        q = (pe * f + 50) / 100;
        if (q > 65535) begin
            v = 65535;
            o = 1;
        end else begin
            v = q;
            o = 0;
        end
`ifdef CALC_SCALE_CLAMP_EN
        o = 0;
`endif
    endtask

    task automatic scramble();
        percent    = PCT_W'($urandom);
        full_scale = WIDTH'($urandom);
    endtask

    // Present a request and let edge 0 accept it; returns #1 after that edge.
    task automatic start_op(input int p, input int f);
        start      = 1'b1;
        percent    = PCT_W'(p);
        full_scale = WIDTH'(f);
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        check("busy_after_accept", busy, 1);
    endtask

    // Count edges after acceptance until done; optionally re-pulse start at 5 and 20.
    task automatic wait_done(input string tag, input int p, input int f, input bit repulse);
        longint ev, eo;
        int got;
        model(p, f, ev, eo);
        got = -1;
        for (int k = 1; k <= LATENCY + 8; k++) begin
            @(posedge clk);
            #1;
            if (repulse && (k == 4 || k == 19)) begin
                start = 1'b1;
                scramble();
            end
            if (repulse && (k == 5 || k == 20)) start = 1'b0;
            if (done) begin
                got = k;
                break;
            end
            if (k == LATENCY - 1) check({tag, "_busy_pre"}, busy, 1);
        end
        check({tag, "_latency"}, got, LATENCY);
        check({tag, "_value"}, value, ev);
        check({tag, "_ovf"}, ovf, eo);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input int p, input int f);
        start_op(p, f);
        wait_done(tag, p, f, 1'b0);
    endtask

    int dir_p [10] = '{50, 1, 33, 1, 100, 200, 0, 75, 255, 101};
    int dir_f [10] = '{1000, 50, 10, 49, 65535, 65535, 40000, 0, 65535, 64000};

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        percent    = '0;
        full_scale = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_value", value, 0);
        check("rst_ovf", ovf, 0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("dir%0d", i), dir_p[i], dir_f[i]);
            @(posedge clk);
            #1;
            check($sformatf("dir%0d_done_pulse", i), done, 0);
        end

        for (int i = 0; i < 12; i++) begin
            int p, f;
            p = $urandom_range(0, 255);
            f = (i % 3 == 0) ? $urandom_range(60000, 65535) : $urandom_range(0, 65535);
            run_op($sformatf("rnd%0d", i), p, f);
        end

        // Starts while busy must be ignored; only the first result appears.
        start_op(40, 3000);
        wait_done("repulse", 40, 3000, 1'b1);

        // Reset mid-operation: back to idle, no done, outputs cleared.
        start_op(90, 5000);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_value", value, 0);
        check("midrst_ovf", ovf, 0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < LATENCY + 4; k++) begin
                @(posedge clk);
                #1;
                if (done) seen++;
            end
            check("midrst_no_done", seen, 0);
        end

        // Back-to-back: next start rides the done cycle.
        start_op(25, 4000);
        wait_done("b2b_a", 25, 4000, 1'b0);
        start_op(67, 12345);
        wait_done("b2b_b", 67, 12345, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int p, f;
            p = $urandom_range(0, 255);
            f = $urandom_range(0, 65535);
            start_op(p, f);
            wait_done($sformatf("b2b_rnd%0d", i), p, f, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
